// File: rtl/ioctl_byte_streamer.sv
// Buffers 32-bit host words in a FIFO and replays them as byte-wide ioctl_wr
// strobes at sequential addresses, framed by ioctl_download and paced by ioctl_wait.
module ioctl_byte_streamer #(
  parameter int FIFO_DEPTH = 16,
  parameter int WR_GAP     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] start_index,
  input  logic        done,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_bytes,
  output logic        ioctl_download,
  output logic [15:0] ioctl_index,
  output logic        ioctl_wr,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_data,
  input  logic        ioctl_wait,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_GAP,
    S_FLUSH
  } state_t;

  state_t state_reg, state_next;

  logic [34:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic [2:0]       norm_bytes;
  logic [34:0]      head_entry;

  logic [15:0]      index_reg;
  logic [24:0]      addr_reg;
  logic             download_reg;
  logic             done_seen_reg;
  logic [31:0]      shift_reg;
  logic [2:0]       bytes_left_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             wr_strobe;

  // ---------------------------------------------------------------- FIFO
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state_reg == S_FETCH) && !fifo_empty;
  assign head_entry = fifo_mem[rd_ptr_reg];

  // Byte count is normalised on entry so the serialiser only ever sees 1..4.
  assign norm_bytes = ((in_bytes == 3'd0) || (in_bytes > 3'd4)) ? 3'd4 : in_bytes;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {norm_bytes, in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          state_next = S_SEND;
        end else if (done_seen_reg) begin
          state_next = S_FLUSH;
        end
      end
      S_SEND: begin
        if (wr_strobe) begin
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        // Leave as the counter reaches zero so the next strobe lands WR_GAP after this one.
        if (gap_cnt_reg <= GAP_W'(1)) begin
          state_next = (bytes_left_reg != 3'd0) ? S_SEND : S_FETCH;
        end
      end
      S_FLUSH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Strobe is combinational on ioctl_wait so a busy sink blocks it in the same cycle.
  always_comb begin
    in_ready   = 1'b0;
    wr_strobe  = 1'b0;
    ioctl_data = 8'h00;
    if (state_reg != S_IDLE) begin
      in_ready = !fifo_full;
    end
    if ((state_reg == S_SEND) && !ioctl_wait && (gap_cnt_reg == '0)) begin
      wr_strobe  = 1'b1;
      ioctl_data = shift_reg[31:24];
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_reg      <= '0;
      addr_reg       <= '0;
      download_reg   <= 1'b0;
      done_seen_reg  <= 1'b0;
      shift_reg      <= '0;
      bytes_left_reg <= '0;
      gap_cnt_reg    <= '0;
    end else begin
      if (state_reg == S_IDLE) begin
        done_seen_reg <= 1'b0;
        if (start) begin
          index_reg    <= start_index;
          addr_reg     <= '0;
          download_reg <= 1'b1;
        end
      end else if (done) begin
        done_seen_reg <= 1'b1;
      end

      if (state_reg == S_FLUSH) begin
        download_reg <= 1'b0;
      end

      if (pop) begin
        shift_reg      <= head_entry[31:0];
        bytes_left_reg <= head_entry[34:32];
      end

      if (wr_strobe) begin
        addr_reg       <= addr_reg + 25'd1;
        shift_reg      <= {shift_reg[23:0], 8'h00};
        bytes_left_reg <= bytes_left_reg - 3'd1;
        gap_cnt_reg    <= GAP_W'(WR_GAP - 1);
      end else if ((state_reg == S_GAP) && (gap_cnt_reg != '0)) begin
        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
      end
    end
  end

  assign ioctl_wr       = wr_strobe;
  assign ioctl_download = download_reg;
  assign ioctl_index    = index_reg;
  assign ioctl_addr     = addr_reg;
  assign busy           = download_reg || !fifo_empty;

endmodule
